branch_update_ctrl: RTL and testbench
=====================================

# branch_update_ctrl

Writer-side companion to the 32-entry 2-bit branch history table. It records the prediction issued for each fetched branch and matches it against the outcome resolved in execute. It drives the table's write port (address plus actual outcome), raises a one-cycle mispredict pulse and discards wrong-path records. After reset it sweeps every table entry to a known state and keeps saturating branch/mispredict statistics.

## Interface
Parameters:
- IDX_W, 5, table index width (table has 2^IDX_W entries)
- DEPTH, 4, in-flight record FIFO depth (power of two, ≥2)
- CNT_W, 16, statistics counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- push_valid  input  1  fetch issues a branch prediction
- push_idx  input  IDX_W  table index (low PC bits) of that branch
- push_pred  input  1  prediction read from the table (1 = taken)
- push_ready  output  1  record accepted this cycle when push_valid & push_ready
- res_valid  input  1  execute resolves the oldest in-flight branch
- res_taken  input  1  actual outcome
- upd_valid  output  1  table write strobe
- upd_addr  output  IDX_W  table write address
- upd_taken  output  1  outcome fed to the table's counter update
- upd_init  output  1  write forces counter to 2'b01 (weakly not-taken), ignoring upd_taken
- mispredict  output  1  one-cycle pulse, prediction differed from outcome
- busy  output  1  init sweep in progress
- underflow  output  1  sticky: res_valid seen with FIFO empty
- br_count, mp_count  output  CNT_W  saturating resolved-branch and mispredict counts

## Operation
- States: INIT, RUN. Reset enters INIT with sweep address 0.
- INIT: each cycle upd_valid=1, upd_init=1, upd_addr=sweep address, which is then incremented. After address 2^IDX_W−1 the FSM moves to RUN. busy=1 and push_ready=0 throughout. res_valid in INIT is ignored and does not set underflow.
- RUN: push_ready = !full | res_valid. A resolve in the same cycle frees a slot.
- Push stores {push_idx, push_pred} at the tail.
- Resolve with non-empty FIFO:
  - Pop the head.
  - Register upd_valid=1, upd_addr=head idx, upd_taken=res_taken, upd_init=0.
  - mispredict = head pred ≠ res_taken.
  - br_count += 1; mp_count += 1 on mispredict. Both saturate at all-ones.
- Mispredict: the whole FIFO is cleared, including any record pushed in the same cycle, because those records are wrong-path.
- Resolve with empty FIFO: no update, no count. underflow is set and stays set until reset.
- Simultaneous push and correct-prediction resolve: occupancy unchanged, record order preserved.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1-valued counter, so full and empty are unambiguous.

## Timing
- Reset values: upd_valid=0, upd_addr=0, upd_taken=0, upd_init=0, mispredict=0, underflow=0, br_count=0, mp_count=0, FIFO empty, busy=1, push_ready=0.
- Asynchronous reset asserted mid-operation: all state returns to the reset values immediately and the sweep restarts at address 0.
- First sweep write is the cycle after rst_n deassertion is sampled. Sweep lasts exactly 2^IDX_W cycles (32 by default), one address per cycle.
- busy falls and push_ready rises in the cycle after the last sweep write.
- Resolve sampled at edge N → upd_*, mispredict and counter changes are visible after edge N; each pulse lasts exactly one cycle.
- Push in cycle N may be resolved in cycle N+1 at the earliest.
- push_ready is combinational from the occupancy, the state and res_valid.

## Test plan
- Reset sweep: release rst_n → upd_addr 0..31 on 32 consecutive cycles with upd_valid=upd_init=1, busy=1; then busy=0, push_ready=1, no further upd_valid.
- Correct prediction: push idx=5 pred=1, then resolve taken=1 → next cycle upd_valid=1, upd_addr=5, upd_taken=1, mispredict=0, br_count=1, mp_count=0.
- Mispredict flush: push idx 3,7,9 (pred 0,1,1), resolve taken=1 → upd_addr=3, mispredict=1, mp_count=1, FIFO empty. A following resolve sets underflow=1 with no upd_valid.
- Full FIFO: push 4 records → push_ready=0. Push and correct resolve in the same cycle → accepted, occupancy stays 4. Order is preserved across wrap (the resolved addresses match the push order).
- Saturation: with CNT_W=4, do 20 mispredicting resolves → br_count=mp_count=15.
- Reset mid-run: assert rst_n=0 with 2 records queued → outputs and counts go to 0 immediately. Release → the sweep restarts at address 0.

Source files
------------

// File: rtl/branch_update_ctrl_if.sv
// Bundle between fetch/execute and branch_update_ctrl: prediction push
// handshake, resolve strobe, table write port and status/statistics.
interface branch_update_if #(
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
);
  logic             push_valid;
  logic [IDX_W-1:0] push_idx;
  logic             push_pred;
  logic             push_ready;
  logic             res_valid;
  logic             res_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_addr;
  logic             upd_taken;
  logic             upd_init;
  logic             mispredict;
  logic             busy;
  logic             underflow;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  // Pipeline side: issues predictions and resolves them.
  modport master (
    output push_valid, push_idx, push_pred, res_valid, res_taken,
    input  push_ready, upd_valid, upd_addr, upd_taken, upd_init,
           mispredict, busy, underflow, br_count, mp_count
  );

  // Controller side.
  modport slave (
    input  push_valid, push_idx, push_pred, res_valid, res_taken,
    output push_ready, upd_valid, upd_addr, upd_taken, upd_init,
           mispredict, busy, underflow, br_count, mp_count
  );
endinterface

// File: rtl/branch_update_ctrl.sv
// Writer-side controller for the 2-bit branch history table. Sweeps the
// table to weakly-not-taken after reset, then queues in-flight predictions,
// writes resolved outcomes back, flags mispredicts (flushing wrong-path
// records) and keeps saturating statistics.
module branch_update_ctrl #(
  parameter int IDX_W = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_update_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [IDX_W:0]   SWEEP_END = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W:0]   sweep_q;
  logic             sweep_done;

  logic [IDX_W-1:0] idx_mem  [DEPTH];
  logic             pred_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  logic running, empty, full;
  logic do_push, do_res, mp_now;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;

  assign sweep_done = (sweep_q == SWEEP_END);
  assign running    = (state_q == ST_RUN);
  assign empty      = (occ_q == '0);
  assign full       = (occ_q == OCC_FULL);
  assign head_idx   = idx_mem[rd_ptr_q];
  assign head_pred  = pred_mem[rd_ptr_q];

  assign bus.push_ready = running & (~full | bus.res_valid);
  assign bus.busy       = ~running;

  assign do_push = bus.push_valid & bus.push_ready;
  assign do_res  = running & bus.res_valid & ~empty;
  assign mp_now  = do_res & (head_pred != bus.res_taken);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next-state: leave INIT once every table entry has been written.
  // NOTE: default assignment first keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Record storage: written on accepted push.
  // NOTE: the array is not reset; occupancy/pointers decide what is valid,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_mem[wr_ptr_q]  <= bus.push_idx;
      pred_mem[wr_ptr_q] <= bus.push_pred;
    end
  end

  // FIFO pointers and occupancy; a mispredict discards everything in flight,
  // including a record pushed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (mp_now) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_res)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_q + OCC_W'(do_push) - OCC_W'(do_res);
    end
  end

  // Registered table write port, mispredict pulse, sweep address and stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q        <= '0;
      bus.upd_valid  <= 1'b0;
      bus.upd_addr   <= '0;
      bus.upd_taken  <= 1'b0;
      bus.upd_init   <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.underflow  <= 1'b0;
      bus.br_count   <= '0;
      bus.mp_count   <= '0;
    end else begin
      bus.upd_valid  <= 1'b0;
      bus.upd_init   <= 1'b0;
      bus.mispredict <= 1'b0;
      if (!running) begin
        if (!sweep_done) begin
          bus.upd_valid <= 1'b1;
          bus.upd_init  <= 1'b1;
          bus.upd_addr  <= sweep_q[IDX_W-1:0];
          bus.upd_taken <= 1'b0;
          sweep_q       <= sweep_q + (IDX_W+1)'(1);
        end
      end else begin
        if (do_res) begin
          bus.upd_valid  <= 1'b1;
          bus.upd_addr   <= head_idx;
          bus.upd_taken  <= bus.res_taken;
          bus.mispredict <= mp_now;
          if (bus.br_count != '1)          bus.br_count <= bus.br_count + CNT_W'(1);
          if (mp_now && bus.mp_count != '1) bus.mp_count <= bus.mp_count + CNT_W'(1);
        end
        if (bus.res_valid && empty) bus.underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Bench for branch_update_ctrl: a default instance and a CNT_W=4 instance
// share stimulus; a queue-based model predicts outputs of both.
module tb_branch_update_ctrl;

  localparam int IDX_W = 5;
  localparam int DEPTH = 4;
  localparam int MAX_W = 65535;
  localparam int MAX_S = 15;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  branch_update_if #(.IDX_W(IDX_W), .CNT_W(16)) bus ();
  branch_update_if #(.IDX_W(IDX_W), .CNT_W(4))  sat_bus ();

  assign sat_bus.push_valid = bus.push_valid;
  assign sat_bus.push_idx   = bus.push_idx;
  assign sat_bus.push_pred  = bus.push_pred;
  assign sat_bus.res_valid  = bus.res_valid;
  assign sat_bus.res_taken  = bus.res_taken;

  branch_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  branch_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  rec_t             q[$];
  int               exp_br, exp_mp, exp_br_s, exp_mp_s;
  bit               exp_under, exp_uv, exp_ut, exp_mis, exp_ready;
  logic [IDX_W-1:0] exp_ua;
  bit               got_ready, got_ready_s;

  task automatic model_reset();
    q.delete();
    exp_br = 0; exp_mp = 0; exp_br_s = 0; exp_mp_s = 0;
    exp_under = 0; exp_uv = 0; exp_ut = 0; exp_mis = 0; exp_ua = '0;
  endtask

  // One RUN-mode cycle: drive inputs, advance the model, inputs idle again.
  task automatic step(input bit pv, input logic [IDX_W-1:0] pi, input bit pp,
                      input bit rv, input bit rt);
    rec_t h;
    bus.push_valid = pv; bus.push_idx = pi; bus.push_pred = pp;
    bus.res_valid  = rv; bus.res_taken = rt;
    #1;
    exp_ready   = (q.size() < DEPTH) || rv;
    got_ready   = bus.push_ready;
    got_ready_s = sat_bus.push_ready;
    @(posedge clk);
    #1;
    exp_uv = 0; exp_mis = 0;
    if (rv) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        exp_uv = 1; exp_ua = h.idx; exp_ut = rt;
        exp_mis = (h.pred != rt);
        if (exp_br < MAX_W) exp_br++;
        if (exp_br_s < MAX_S) exp_br_s++;
        if (exp_mis && exp_mp < MAX_W) exp_mp++;
        if (exp_mis && exp_mp_s < MAX_S) exp_mp_s++;
      end else begin
        exp_under = 1;
      end
    end
    if (pv && exp_ready) q.push_back({pi, pp});
    if (exp_mis) q.delete();
    bus.push_valid = 0; bus.push_idx = '0; bus.push_pred = 0;
    bus.res_valid = 0; bus.res_taken = 0;
  endtask

  // Reset values (asserted asynchronously), then the full init sweep.
  task automatic test_reset(input string tag);
    rst_n = 1'b0;
    bus.res_valid = 1; bus.push_valid = 1;
    #1;
    n_cmp++;
    if ({bus.upd_valid, bus.upd_addr, bus.upd_taken, bus.upd_init, bus.mispredict,
         bus.underflow, bus.busy, bus.push_ready} !== {1'b0, 5'd0, 4'b0000, 2'b10}) begin
      n_bad++;
      $display("FAIL %s_reset_outputs: got v=%b a=%0d t=%b i=%b m=%b u=%b busy=%b rdy=%b want zeros busy=1 rdy=0",
               tag, bus.upd_valid, bus.upd_addr, bus.upd_taken, bus.upd_init,
               bus.mispredict, bus.underflow, bus.busy, bus.push_ready);
    end
    n_cmp++;
    if (bus.br_count !== 16'd0 || bus.mp_count !== 16'd0 ||
        sat_bus.br_count !== 4'd0 || sat_bus.mp_count !== 4'd0) begin
      n_bad++;
      $display("FAIL %s_reset_counts: got br=%0d mp=%0d sbr=%0d smp=%0d want all 0",
               tag, bus.br_count, bus.mp_count, sat_bus.br_count, sat_bus.mp_count);
    end
    model_reset();
    bus.res_valid = 0; bus.push_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < (1 << IDX_W); i++) begin
      bus.res_valid  = i[0];
      bus.push_valid = i[1];
      #1;
      n_cmp++;
      if (bus.push_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_sweep_ready: cycle %0d got %b want 0", tag, i, bus.push_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.upd_valid, bus.upd_init, bus.busy, bus.push_ready} !== 4'b1110 ||
          bus.upd_addr !== IDX_W'(i)) begin
        n_bad++;
        $display("FAIL %s_sweep_write: cycle %0d got v=%b i=%b busy=%b rdy=%b a=%0d want 1 1 1 0 a=%0d",
                 tag, i, bus.upd_valid, bus.upd_init, bus.busy, bus.push_ready, bus.upd_addr, i);
      end
    end
    bus.res_valid = 0; bus.push_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.upd_valid, bus.busy, bus.push_ready, bus.underflow} !== 4'b0010) begin
        n_bad++;
        $display("FAIL %s_after_sweep: cycle %0d got v=%b busy=%b rdy=%b uf=%b want 0 0 1 0",
                 tag, i, bus.upd_valid, bus.busy, bus.push_ready, bus.underflow);
      end
    end
  endtask

  task automatic test_correct();
    step(1, 5'd5, 1, 0, 0);
    step(0, '0, 0, 1, 1);
    n_cmp++;
    if ({bus.upd_valid, bus.upd_init, bus.upd_taken, bus.mispredict} !== 4'b1010 ||
        bus.upd_addr !== 5'd5) begin
      n_bad++;
      $display("FAIL correct_update: got v=%b i=%b t=%b m=%b a=%0d want 1 0 1 0 a=5",
               bus.upd_valid, bus.upd_init, bus.upd_taken, bus.mispredict, bus.upd_addr);
    end
    n_cmp++;
    if (bus.br_count !== 16'(exp_br) || bus.mp_count !== 16'(exp_mp) || exp_br != 1) begin
      n_bad++;
      $display("FAIL correct_counts: got br=%0d mp=%0d want br=%0d mp=%0d",
               bus.br_count, bus.mp_count, exp_br, exp_mp);
    end
    step(0, '0, 0, 0, 0);
    n_cmp++;
    if (bus.upd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL correct_pulse_width: got upd_valid=%b want 0", bus.upd_valid);
    end
  endtask

  task automatic test_full();
    bit p;
    for (int i = 0; i < DEPTH; i++) step(1, IDX_W'(10 + i), 1'($urandom), 0, 0);
    step(1, 5'd14, 0, 0, 0);
    n_cmp++;
    if (got_ready !== exp_ready || exp_ready) begin
      n_bad++;
      $display("FAIL full_ready_low: got %b want 0", got_ready);
    end
    p = q[0].pred;
    step(1, 5'd15, 1'($urandom), 1, p);
    n_cmp++;
    if (got_ready !== 1'b1 || bus.upd_addr !== 5'd10 || bus.upd_valid !== 1'b1 ||
        q.size() != DEPTH) begin
      n_bad++;
      $display("FAIL full_push_and_resolve: got rdy=%b v=%b a=%0d occ=%0d want 1 1 10 occ=4",
               got_ready, bus.upd_valid, bus.upd_addr, q.size());
    end
    for (int i = 0; i < DEPTH; i++) begin
      p = q[0].pred;
      step(0, '0, 0, 1, p);
      n_cmp++;
      if (bus.upd_valid !== 1'b1 || bus.upd_addr !== exp_ua || bus.mispredict !== 1'b0) begin
        n_bad++;
        $display("FAIL full_order: resolve %0d got v=%b a=%0d m=%b want 1 a=%0d m=0",
                 i, bus.upd_valid, bus.upd_addr, bus.mispredict, exp_ua);
      end
    end
  endtask

  task automatic test_mispredict();
    step(1, 5'd3, 0, 0, 0);
    step(1, 5'd7, 1, 0, 0);
    step(1, 5'd9, 1, 0, 0);
    step(1, 5'd20, 0, 1, 1);
    n_cmp++;
    if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 5'd3 || bus.upd_taken !== 1'b1 ||
        bus.mispredict !== 1'b1 || bus.mp_count !== 16'(exp_mp)) begin
      n_bad++;
      $display("FAIL mispredict_update: got v=%b a=%0d t=%b m=%b mp=%0d want 1 3 1 1 mp=%0d",
               bus.upd_valid, bus.upd_addr, bus.upd_taken, bus.mispredict, bus.mp_count, exp_mp);
    end
    step(0, '0, 0, 1, 0);
    n_cmp++;
    if (bus.upd_valid !== 1'b0 || bus.mispredict !== 1'b0 || bus.underflow !== 1'b1 ||
        sat_bus.underflow !== 1'b1 || bus.br_count !== 16'(exp_br)) begin
      n_bad++;
      $display("FAIL mispredict_flush_underflow: got v=%b m=%b uf=%b suf=%b br=%0d want 0 0 1 1 br=%0d",
               bus.upd_valid, bus.mispredict, bus.underflow, sat_bus.underflow, bus.br_count, exp_br);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      step(1, IDX_W'(i), 0, 0, 0);
      step(0, '0, 0, 1, 1);
    end
    n_cmp++;
    if (sat_bus.br_count !== 4'd15 || sat_bus.mp_count !== 4'd15 ||
        exp_br_s != MAX_S || exp_mp_s != MAX_S) begin
      n_bad++;
      $display("FAIL saturation_small: got br=%0d mp=%0d want 15 15",
               sat_bus.br_count, sat_bus.mp_count);
    end
    n_cmp++;
    if (bus.br_count !== 16'(exp_br) || bus.mp_count !== 16'(exp_mp)) begin
      n_bad++;
      $display("FAIL saturation_wide: got br=%0d mp=%0d want %0d %0d",
               bus.br_count, bus.mp_count, exp_br, exp_mp);
    end
  endtask

  task automatic test_random();
    bit pv, rv, rt;
    for (int n = 0; n < 400; n++) begin
      pv = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 2) != 0) && (q.size() > 0 || $urandom_range(0, 15) == 0);
      if (q.size() > 0) rt = ($urandom_range(0, 7) == 0) ? ~q[0].pred : q[0].pred;
      else              rt = 1'($urandom);
      step(pv, IDX_W'($urandom), 1'($urandom), rv, rt);
      n_cmp++;
      if ({got_ready, got_ready_s, bus.upd_valid, sat_bus.upd_valid, bus.mispredict,
           sat_bus.mispredict, bus.underflow, bus.upd_init} !==
          {exp_ready, exp_ready, exp_uv, exp_uv, exp_mis, exp_mis, exp_under, 1'b0}) begin
        n_bad++;
        $display("FAIL random_flags: cycle %0d got rdy=%b/%b v=%b/%b m=%b/%b uf=%b i=%b want rdy=%b v=%b m=%b uf=%b i=0",
                 n, got_ready, got_ready_s, bus.upd_valid, sat_bus.upd_valid, bus.mispredict,
                 sat_bus.mispredict, bus.underflow, bus.upd_init, exp_ready, exp_uv, exp_mis, exp_under);
      end
      if (exp_uv) begin
        n_cmp++;
        if (bus.upd_addr !== exp_ua || bus.upd_taken !== exp_ut || sat_bus.upd_addr !== exp_ua) begin
          n_bad++;
          $display("FAIL random_update: cycle %0d got a=%0d t=%b sa=%0d want a=%0d t=%b",
                   n, bus.upd_addr, bus.upd_taken, sat_bus.upd_addr, exp_ua, exp_ut);
        end
      end
      n_cmp++;
      if (bus.br_count !== 16'(exp_br) || bus.mp_count !== 16'(exp_mp) ||
          sat_bus.br_count !== 4'(exp_br_s) || sat_bus.mp_count !== 4'(exp_mp_s)) begin
        n_bad++;
        $display("FAIL random_counts: cycle %0d got br=%0d mp=%0d sbr=%0d smp=%0d want %0d %0d %0d %0d",
                 n, bus.br_count, bus.mp_count, sat_bus.br_count, sat_bus.mp_count,
                 exp_br, exp_mp, exp_br_s, exp_mp_s);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    while (q.size() > 0) step(0, '0, 0, 1, q[0].pred);
    step(1, 5'd21, 1, 0, 0);
    step(1, 5'd22, 0, 0, 0);
    step(1, 5'd23, 1, 0, 0);
    step(0, '0, 0, 1, 1);
    n_cmp++;
    if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 5'd21 || q.size() != 2) begin
      n_bad++;
      $display("FAIL midrun_setup: got v=%b a=%0d occ=%0d want 1 21 occ=2",
               bus.upd_valid, bus.upd_addr, q.size());
    end
    test_reset("midrun");
    step(0, '0, 0, 1, 0);
    n_cmp++;
    if (bus.upd_valid !== 1'b0 || bus.underflow !== 1'b1 || bus.br_count !== 16'd0) begin
      n_bad++;
      $display("FAIL midrun_fifo_cleared: got v=%b uf=%b br=%0d want 0 1 0",
               bus.upd_valid, bus.underflow, bus.br_count);
    end
  endtask

  initial begin
    bus.push_valid = 0; bus.push_idx = '0; bus.push_pred = 0;
    bus.res_valid = 0; bus.res_taken = 0;
    model_reset();
    test_reset("initial");
    test_correct();
    test_full();
    test_mispredict();
    test_saturation();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
